// File: rtl/bc_seq_ctrl_if.sv
// bc_seq_ctrl_if: datapath <-> sequencer signal bundle.
// master = sequencer side, slave = datapath side.
interface bc_seq_ctrl_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_IRQ = 4,
    parameter int IDW     = 4
);
    logic [WIDTH-1:0]   ir;
    logic               z;
    logic               n;
    logic               e_in;
    logic [NUM_IRQ-1:0] irq_req;
    logic               fgi;
    logic               fgo;
    logic [2:0]         bus_sel;
    logic [17:0]        ctrl;
    logic [2:0]         alu_op;
    logic [NUM_IRQ-1:0] irq_ack;
    logic [IDW-1:0]     irq_id;
    logic               ien;
    logic               halted;

    modport master (
        input  ir, z, n, e_in, irq_req, fgi, fgo,
        output bus_sel, ctrl, alu_op, irq_ack,
        output irq_id, ien, halted
    );

    modport slave (
        output ir, z, n, e_in, irq_req, fgi, fgo,
        input  bus_sel, ctrl, alu_op, irq_ack,
        input  irq_id, ien, halted
    );
endinterface

// File: rtl/bc_seq_ctrl.sv
// bc_seq_ctrl: hardwired control sequencer for the basic-computer datapath.
// Define IO_INSTR_EN to enable the INP/OUT/SKI/SKO I/O instruction group.
module bc_seq_ctrl #(
    parameter int WIDTH   = 16,
    parameter int NUM_IRQ = 4,
    parameter int IDW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    bc_seq_ctrl_if.master cif
);

    localparam logic [2:0] B_AR  = 3'd0;
    localparam logic [2:0] B_PC  = 3'd1;
    localparam logic [2:0] B_DR  = 3'd2;
    localparam logic [2:0] B_AC  = 3'd3;
    localparam logic [2:0] B_IR  = 3'd4;
    localparam logic [2:0] B_TR  = 3'd5;
    localparam logic [2:0] B_MEM = 3'd6;

    localparam int C_AR_LD   = 0;
    localparam int C_AR_INR  = 1;
    localparam int C_AR_CLR  = 2;
    localparam int C_PC_LD   = 3;
    localparam int C_PC_INR  = 4;
    localparam int C_PC_CLR  = 5;
    localparam int C_DR_LD   = 6;
    localparam int C_DR_INR  = 7;
    localparam int C_AC_LD   = 8;
    localparam int C_AC_INR  = 9;
    localparam int C_AC_CLR  = 10;
    localparam int C_IR_LD   = 11;
    localparam int C_TR_LD   = 12;
    localparam int C_MEM_WR  = 13;
    localparam int C_E_CLR   = 14;
    localparam int C_E_CMP   = 15;
`ifdef IO_INSTR_EN
    localparam int C_INP_LD  = 16;
    localparam int C_OUTR_LD = 17;
`endif

    localparam logic [2:0] A_ADD  = 3'd0;
    localparam logic [2:0] A_AND  = 3'd1;
    localparam logic [2:0] A_PASS = 3'd2;
    localparam logic [2:0] A_CMA  = 3'd3;
    localparam logic [2:0] A_CIR  = 3'd4;
    localparam logic [2:0] A_CIL  = 3'd5;
    localparam logic [2:0] A_IDLE = 3'd7;

    typedef enum logic [3:0] {
        S_F0,
        S_F1,
        S_DEC,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_INT0,
        S_INT1,
        S_INT2,
        S_HALT
    } state_t;

    state_t             state;
    state_t             nxt;
    logic               i_q;
    logic [7:0]         d_q;
    logic               ien_q;
    logic               ien_nxt;
    logic [IDW-1:0]     irq_id_q;
    logic               done;
    logic               hlt;
    logic               ien_set;
    logic               ien_clr;
    logic [11:0]        fn;
    logic [2:0]         bus_sel;
    logic [17:0]        ctrl;
    logic [2:0]         alu_op;
    logic [NUM_IRQ-1:0] irq_ack;

    assign fn = cif.ir[11:0];

    function automatic logic [IDW-1:0] lowest(
        input logic [NUM_IRQ-1:0] r
    );
        logic [IDW-1:0] id;
        id = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--)
            if (r[k]) id = IDW'(k);
        return id;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_F0;
            i_q      <= 1'b0;
            d_q      <= '0;
            ien_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            state <= nxt;
            ien_q <= ien_nxt;
            if (state == S_DEC) begin
                i_q <= cif.ir[WIDTH-1];
                d_q <= 8'b1 << cif.ir[WIDTH-2:WIDTH-4];
            end
            // Channel is frozen on entry; later request changes are ignored.
            if (nxt == S_INT0)
                irq_id_q <= lowest(cif.irq_req);
        end
    end

    always_comb begin
        nxt     = state;
        bus_sel = B_AR;
        ctrl    = '0;
        alu_op  = A_IDLE;
        irq_ack = '0;
        done    = 1'b0;
        hlt     = 1'b0;
        ien_set = 1'b0;
        ien_clr = 1'b0;
        if (!rst) begin
            unique case (state)
                S_F0: begin
                    bus_sel        = B_PC;
                    ctrl[C_AR_LD]  = 1'b1;
                    nxt            = S_F1;
                end
                S_F1: begin
                    bus_sel        = B_MEM;
                    ctrl[C_IR_LD]  = 1'b1;
                    ctrl[C_PC_INR] = 1'b1;
                    nxt            = S_DEC;
                end
                S_DEC: begin
                    bus_sel       = B_IR;
                    ctrl[C_AR_LD] = 1'b1;
                    nxt           = S_T3;
                end
                S_T3: begin
                    if (d_q[7]) begin
                        done = 1'b1;
                        if (!i_q) begin
                            if (fn[11]) ctrl[C_AC_CLR] = 1'b1;
                            else if (fn[10]) ctrl[C_E_CLR] = 1'b1;
                            else if (fn[9]) begin
                                alu_op        = A_CMA;
                                ctrl[C_AC_LD] = 1'b1;
                            end
                            else if (fn[8]) ctrl[C_E_CMP] = 1'b1;
                            else if (fn[7]) begin
                                alu_op        = A_CIR;
                                ctrl[C_AC_LD] = 1'b1;
                            end
                            else if (fn[6]) begin
                                alu_op        = A_CIL;
                                ctrl[C_AC_LD] = 1'b1;
                            end
                            else if (fn[5]) ctrl[C_AC_INR] = 1'b1;
                            else if (fn[4]) ctrl[C_PC_INR] = ~cif.n;
                            else if (fn[3]) ctrl[C_PC_INR] = cif.n;
                            else if (fn[2]) ctrl[C_PC_INR] = cif.z;
                            else if (fn[1]) ctrl[C_PC_INR] = ~cif.e_in;
                            else if (fn[0]) hlt = 1'b1;
                        end else begin
`ifdef IO_INSTR_EN
                            if (fn[11]) ctrl[C_INP_LD] = 1'b1;
                            else if (fn[10]) ctrl[C_OUTR_LD] = 1'b1;
                            else if (fn[9]) ctrl[C_PC_INR] = cif.fgi;
                            else if (fn[8]) ctrl[C_PC_INR] = cif.fgo;
                            else if (fn[7]) ien_set = 1'b1;
                            else if (fn[6]) ien_clr = 1'b1;
`else
                            if (fn[7]) ien_set = 1'b1;
                            else if (fn[6]) ien_clr = 1'b1;
`endif
                        end
                    end else begin
                        if (i_q) begin
                            bus_sel       = B_MEM;
                            ctrl[C_AR_LD] = 1'b1;
                        end
                        nxt = S_T4;
                    end
                end
                S_T4: begin
                    nxt = S_T5;
                    unique case (1'b1)
                        d_q[0], d_q[1], d_q[2], d_q[6]: begin
                            bus_sel       = B_MEM;
                            ctrl[C_DR_LD] = 1'b1;
                        end
                        d_q[3]: begin
                            bus_sel        = B_AC;
                            ctrl[C_MEM_WR] = 1'b1;
                            done           = 1'b1;
                        end
                        d_q[4]: begin
                            bus_sel       = B_AR;
                            ctrl[C_PC_LD] = 1'b1;
                            done          = 1'b1;
                        end
                        d_q[5]: begin
                            bus_sel        = B_PC;
                            ctrl[C_MEM_WR] = 1'b1;
                            ctrl[C_AR_INR] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    done = 1'b1;
                    unique case (1'b1)
                        d_q[0]: begin
                            alu_op        = A_AND;
                            ctrl[C_AC_LD] = 1'b1;
                        end
                        d_q[1]: begin
                            alu_op        = A_ADD;
                            ctrl[C_AC_LD] = 1'b1;
                        end
                        d_q[2]: begin
                            alu_op        = A_PASS;
                            ctrl[C_AC_LD] = 1'b1;
                        end
                        d_q[5]: begin
                            bus_sel       = B_AR;
                            ctrl[C_PC_LD] = 1'b1;
                        end
                        d_q[6]: begin
                            ctrl[C_DR_INR] = 1'b1;
                            done           = 1'b0;
                            nxt            = S_T6;
                        end
                        default: ;
                    endcase
                end
                S_T6: begin
                    bus_sel        = B_DR;
                    ctrl[C_MEM_WR] = 1'b1;
                    ctrl[C_PC_INR] = cif.z;
                    done           = 1'b1;
                end
                S_INT0: begin
                    bus_sel        = B_PC;
                    ctrl[C_AR_CLR] = 1'b1;
                    ctrl[C_TR_LD]  = 1'b1;
                    nxt            = S_INT1;
                end
                S_INT1: begin
                    bus_sel        = B_TR;
                    ctrl[C_MEM_WR] = 1'b1;
                    ctrl[C_PC_CLR] = 1'b1;
                    nxt            = S_INT2;
                end
                S_INT2: begin
                    ctrl[C_PC_INR] = 1'b1;
                    ien_clr        = 1'b1;
                    irq_ack        = NUM_IRQ'(1) << irq_id_q;
                    nxt            = S_F0;
                end
                S_HALT: nxt = S_HALT;
                default: nxt = S_F0;
            endcase
        end
        ien_nxt = ien_set ? 1'b1 : (ien_clr ? 1'b0 : ien_q);
        // ION with a pending request takes the interrupt right away.
        if (done) begin
            if (hlt)
                nxt = S_HALT;
            else if (ien_nxt && |cif.irq_req)
                nxt = S_INT0;
            else
                nxt = S_F0;
        end
    end

`ifndef IO_INSTR_EN
    logic unused_io;
    assign unused_io = cif.fgi ^ cif.fgo;
`endif

    assign cif.bus_sel = bus_sel;
    assign cif.ctrl    = ctrl;
    assign cif.alu_op  = alu_op;
    assign cif.irq_ack = irq_ack;
    assign cif.irq_id  = irq_id_q;
    assign cif.ien     = ien_q;
    assign cif.halted  = (state == S_HALT);

endmodule
